// File: rtl/bus_pkg.sv
// Shared types and defaults for the serial bit-level system bus.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    WDATA   = 3'd2,
    MEM_WR  = 3'd3,
    RD_REQ  = 3'd4,
    RD_WAIT = 3'd5,
    SPLIT   = 3'd6,
    RD_SEND = 3'd7
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int DEF_ADDR_WIDTH      = 11;
  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_SPLIT_THRESHOLD = 4;

  // Largest of three sizes, used to size the shared beat/wait counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Right-shifting register: serial-in at the MSB, serial-out at the LSB,
// with synchronous clear and parallel load. lsb_next is the LSB value the
// register will hold after the coming clock edge.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             lsb_next
);

  logic [WIDTH-1:0] q_next_s;

  // Next value: clear beats load beats shift beats hold.
  always_comb begin
    q_next_s = q;
    if (clr) begin
      q_next_s = {WIDTH{1'b0}};
    end else if (load) begin
      q_next_s = par_in;
    end else if (shift) begin
      q_next_s = {ser_in, q[WIDTH-1:1]};
    end else begin
      q_next_s = q;
    end
  end

  assign lsb_next = q_next_s[0];

  // Register update with asynchronous reset to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {WIDTH{1'b0}};
    end else begin
      q <= q_next_s;
    end
  end

endmodule

// File: rtl/split_slave_port.sv
// Responder port on the serial bus: shifts in address/write data, drives a
// local memory, serialises read data back, and releases the bus (split)
// while a slow read is outstanding.
module split_slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int SPLIT_THRESHOLD = DEF_SPLIT_THRESHOLD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  wr_bus,
  input  logic                  master_valid,
  output logic                  slave_ready,
  output logic                  rd_bus,
  output logic                  slave_valid,
  input  logic                  master_ready,
  output logic                  split,
  input  logic                  split_grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int CNT_MAX = max3(ADDR_WIDTH, DATA_WIDTH, SPLIT_THRESHOLD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Bit 0 of the address is taken in IDLE, so ADDR counts the remaining bits.
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 2);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SPLIT_THRESHOLD - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             mode_r, mode_s;
  logic             has_data_r, has_data_s;
  logic             in_beat_s, out_beat_s;
  logic             addr_shift_s, wd_shift_s, tx_load_s, tx_shift_s;
  logic             tx_lsb_next_s;
  logic [DATA_WIDTH-1:0] tx_q_unused_s;
  logic             addr_lsb_unused_s, wd_lsb_unused_s;
  logic             slave_ready_r, slave_valid_r, rd_bus_r;
  logic             split_r, mem_wen_r, mem_ren_r;

  assign in_beat_s  = master_valid & slave_ready_r;
  assign out_beat_s = slave_valid_r & master_ready;

  // Next-state, counter and shift-register control decode.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    mode_s       = mode_r;
    has_data_s   = 1'b0;
    addr_shift_s = 1'b0;
    wd_shift_s   = 1'b0;
    tx_load_s    = 1'b0;
    tx_shift_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_beat_s) begin
          mode_s       = mode;
          addr_shift_s = 1'b1;
          cnt_s        = {CNT_W{1'b0}};
          state_s      = ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (in_beat_s) begin
          addr_shift_s = 1'b1;
          if (cnt_r == ADDR_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = (mode_r == MODE_WRITE) ? WDATA : RD_REQ;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = ADDR;
        end
      end
      WDATA: begin
        if (in_beat_s) begin
          wd_shift_s = 1'b1;
          if (cnt_r == DATA_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = MEM_WR;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = WDATA;
        end
      end
      MEM_WR: begin
        state_s = IDLE;
      end
      RD_REQ: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = RD_WAIT;
      end
      RD_WAIT: begin
        // Data arriving on the threshold cycle takes priority over a split.
        if (mem_rvalid) begin
          tx_load_s = 1'b1;
          cnt_s     = {CNT_W{1'b0}};
          state_s   = RD_SEND;
        end else if (cnt_r == WAIT_LAST) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = SPLIT;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      SPLIT: begin
        // A grant only counts once the data is already held.
        if (has_data_r && split_grant) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = RD_SEND;
        end else begin
          tx_load_s  = mem_rvalid & ~has_data_r;
          has_data_s = has_data_r | mem_rvalid;
        end
      end
      RD_SEND: begin
        if (out_beat_s) begin
          tx_shift_s = 1'b1;
          if (cnt_r == DATA_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = RD_SEND;
        end
      end
      default: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, counter and transaction bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      mode_r     <= MODE_READ;
      has_data_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      mode_r     <= mode_s;
      has_data_r <= has_data_s;
    end
  end

  // Bus and memory strobes registered from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slave_ready_r <= 1'b0;
      slave_valid_r <= 1'b0;
      rd_bus_r      <= 1'b0;
      split_r       <= 1'b0;
      mem_wen_r     <= 1'b0;
      mem_ren_r     <= 1'b0;
    end else begin
      slave_ready_r <= (state_s == IDLE) || (state_s == ADDR) || (state_s == WDATA);
      slave_valid_r <= (state_s == RD_SEND);
      rd_bus_r      <= (state_s == RD_SEND) & tx_lsb_next_s;
      split_r       <= (state_s == SPLIT);
      mem_wen_r     <= (state_s == MEM_WR);
      mem_ren_r     <= (state_s == RD_REQ);
    end
  end

  serial_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (1'b0),
    .shift    (addr_shift_s),
    .ser_in   (wr_bus),
    .par_in   ({ADDR_WIDTH{1'b0}}),
    .q        (mem_addr),
    .lsb_next (addr_lsb_unused_s)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_wdata_sr (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (1'b0),
    .shift    (wd_shift_s),
    .ser_in   (wr_bus),
    .par_in   ({DATA_WIDTH{1'b0}}),
    .q        (mem_wdata),
    .lsb_next (wd_lsb_unused_s)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_rdata_sr (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (tx_load_s),
    .shift    (tx_shift_s),
    .ser_in   (1'b0),
    .par_in   (mem_rdata),
    .q        (tx_q_unused_s),
    .lsb_next (tx_lsb_next_s)
  );

  assign slave_ready = slave_ready_r;
  assign slave_valid = slave_valid_r;
  assign rd_bus      = rd_bus_r;
  assign split       = split_r;
  assign mem_wen     = mem_wen_r;
  assign mem_ren     = mem_ren_r;

endmodule

// File: tb/tb_split_slave_port.sv
// Directed scoreboard bench for split_slave_port.
module tb_split_slave_port;

  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          wr_bus;
  logic          master_valid;
  logic          slave_ready;
  logic          rd_bus;
  logic          slave_valid;
  logic          master_ready;
  logic          split;
  logic          split_grant;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic          mem_ren;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_q[$];
  logic        bit_q[$];

  always #5 clk = ~clk;

  split_slave_port dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .wr_bus       (wr_bus),
    .master_valid (master_valid),
    .slave_ready  (slave_ready),
    .rd_bus       (rd_bus),
    .slave_valid  (slave_valid),
    .master_ready (master_ready),
    .split        (split),
    .split_grant  (split_grant),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wen      (mem_wen),
    .mem_ren      (mem_ren),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, slave_ready, 0);
    chk({tag, "_valid"}, slave_valid, 0);
    chk({tag, "_rdbus"}, rd_bus, 0);
    chk({tag, "_split"}, split, 0);
    chk({tag, "_wen"}, mem_wen, 0);
    chk({tag, "_ren"}, mem_ren, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  // Shift n bits of v LSB first; optionally drop master_valid for 3 cycles before bit stall_at.
  task automatic send_bits(input logic [31:0] v, input int n, input int stall_at, input string tag);
    logic acc;
    int   guard;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        master_valid = 1'b0;
        wr_bus       = ~v[i];
        repeat (3) tick();
      end
      master_valid = 1'b1;
      wr_bus       = v[i];
      acc          = 1'b0;
      guard        = 0;
      while (!acc && guard < 8) begin
        acc = slave_ready;
        tick();
        guard++;
      end
      chk({tag, "_accept"}, acc, 1);
    end
    master_valid = 1'b0;
    wr_bus       = 1'b0;
  endtask

  task automatic push_bits(input logic [7:0] d);
    for (int i = 0; i < DW; i++) bit_q.push_back(d[i]);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] e;
    mode = 1'b1;
    wr_q.push_back((addr << 8) | (data & 32'h0000_00FF));
    send_bits(addr, AW, -1, "waddr");
    send_bits(data, DW, -1, "wdata");
    chk("wen_latency", mem_wen, 1);
    e = wr_q.pop_front();
    chk("wr_addr", mem_addr, e[18:8]);
    chk("wr_data", mem_wdata, e[7:0]);
    chk("wr_ready_low", slave_ready, 0);
    tick();
    chk("wen_once", mem_wen, 0);
    chk("ready_back", slave_ready, 1);
  endtask

  task automatic start_read(input logic [31:0] addr, input int stall_at);
    mode = 1'b0;
    send_bits(addr, AW, stall_at, "raddr");
    chk("mem_ren", mem_ren, 1);
    chk("rd_addr", mem_addr, addr);
  endtask

  // Memory answers during the d-th wait cycle after mem_ren; no split expected.
  task automatic fast_respond(input int d, input logic [7:0] data);
    for (int c = 1; c <= d; c++) begin
      tick();
      chk("wait_no_split", split, 0);
      chk("ren_once", mem_ren, 0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 8'($urandom);
    chk("fast_no_split", split, 0);
    chk("fast_send", slave_valid, 1);
  endtask

  // Collect DW read beats, optionally holding master_ready low for 2 cycles at beat stall_at.
  task automatic recv_byte(input int stall_at);
    int   g;
    logic held;
    logic e;
    for (int i = 0; i < DW; i++) begin
      g = 0;
      while (!slave_valid && g < 30) begin
        tick();
        g++;
      end
      chk("rd_valid", slave_valid, 1);
      if (i == stall_at) begin
        held         = rd_bus;
        master_ready = 1'b0;
        repeat (2) begin
          tick();
          chk("rd_hold", rd_bus, held);
          chk("rd_hold_valid", slave_valid, 1);
        end
        master_ready = 1'b1;
      end
      e = bit_q.pop_front();
      chk("rd_bit", rd_bus, e);
      tick();
    end
    chk("rd_done_valid", slave_valid, 0);
    chk("rd_done_bus", rd_bus, 0);
  endtask

  initial begin
    rst          = 1'b1;
    mode         = 1'b0;
    wr_bus       = 1'b0;
    master_valid = 1'b0;
    master_ready = 1'b1;
    split_grant  = 1'b0;
    mem_rdata    = 8'h00;
    mem_rvalid   = 1'b0;

    // Reset state
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    chk("ready_pre_clk", slave_ready, 0);
    tick();
    chk("ready_post_clk", slave_ready, 1);

    // Write 0x2A5 <- 0x3C
    do_write(32'h2A5, 32'h3C);

    // Fast read with 3-cycle master_valid gap mid-address
    start_read(32'h010, 5);
    push_bits(8'h5A);
    fast_respond(2, 8'h5A);
    recv_byte(-1);

    // Split read: data after 10 cycles, early grant ignored, backpressure on beat 3
    start_read(32'h123, -1);
    push_bits(8'hC3);
    repeat (4) begin
      tick();
      chk("pre_split_low", split, 0);
    end
    tick();
    chk("split_rise", split, 1);
    split_grant = 1'b1;
    repeat (2) begin
      tick();
      chk("early_grant_split", split, 1);
      chk("early_grant_valid", slave_valid, 0);
    end
    split_grant = 1'b0;
    repeat (3) begin
      tick();
      chk("split_hold", split, 1);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 8'hC3;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    chk("captured_split", split, 1);
    chk("captured_valid", slave_valid, 0);
    tick();
    chk("await_grant", split, 1);
    split_grant = 1'b1;
    tick();
    split_grant = 1'b0;
    chk("grant_split_low", split, 0);
    chk("grant_send", slave_valid, 1);
    recv_byte(3);

    // Boundary: data on the 4th wait cycle wins over split
    start_read(32'h7FF, -1);
    push_bits(8'h96);
    fast_respond(4, 8'h96);
    recv_byte(-1);

    // Reset during WDATA bit 5
    mode = 1'b1;
    send_bits(32'h0F0, AW, -1, "xaddr");
    send_bits(32'hFF, 5, -1, "xdata");
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    repeat (3) begin
      tick();
      chk("mid_reset_no_wen", mem_wen, 0);
    end
    rst = 1'b0;
    tick();
    chk("ready_after_abort", slave_ready, 1);
    do_write(32'h1F0, 32'hA7);

    chk("scoreboard_empty", wr_q.size() + bit_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
